// File: rtl/bsc_axiu_hs_to_stream_packetizer.sv
// bsc_axiu_hs_to_stream_packetizer
// Converts an HLS ap_hs output into a framed AXI4-Stream. Each packet starts
// with a header word (len = in_hs[15:0], id = in_hs[23:16]). The header is
// forwarded as a beat and is followed by len payload beats. tlast marks the
// final beat, and every beat of the packet carries tid = id. A 2-entry FIFO
// decouples in_hs_ap_ack from outStream_tready.
//
// Ports:
//   aclk, aresetn       clock, synchronous active-low reset
//   in_hs[63:0]         accelerator data
//   in_hs_ap_vld        accelerator data valid (held until acked)
//   in_hs_ap_ack        word accepted (depends on occupancy only)
//   outStream_tdata     stream data (head entry)
//   outStream_tvalid    stream valid (buffer non-empty)
//   outStream_tready    downstream ready
//   outStream_tlast     last beat of packet
//   outStream_tid       packet id
// Parameter USE_PACKET_FRAMING: 1 = header framing, 0 = every word is a
// single-beat packet with tlast=1, tid=0.
module bsc_axiu_hs_to_stream_packetizer #(
  parameter int unsigned USE_PACKET_FRAMING = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [63:0] in_hs,
  input  logic        in_hs_ap_vld,
  output logic        in_hs_ap_ack,
  output logic [63:0] outStream_tdata,
  output logic        outStream_tvalid,
  input  logic        outStream_tready,
  output logic        outStream_tlast,
  output logic [7:0]  outStream_tid
);

  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [63:0] mem_data [2];
  logic        mem_last [2];
  logic [7:0]  mem_tid  [2];

  logic        push;
  logic        pop;
  logic        in_last;
  logic [7:0]  in_tid;

  assign in_hs_ap_ack     = aresetn && (count != 2'd2);
  assign push             = in_hs_ap_vld && in_hs_ap_ack;
  assign outStream_tvalid = (count != 2'd0);
  assign pop              = outStream_tvalid && outStream_tready;

  assign outStream_tdata  = mem_data[rd_ptr];
  assign outStream_tlast  = mem_last[rd_ptr];
  assign outStream_tid    = mem_tid[rd_ptr];

  generate
    if (USE_PACKET_FRAMING != 0) begin : g_framing
      typedef enum logic {S_HEADER, S_PAYLOAD} state_t;

      state_t      state, state_nxt;
      logic [15:0] rem, rem_nxt;
      logic [7:0]  cur_tid, cur_tid_nxt;

      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          state   <= S_HEADER;
          rem     <= '0;
          cur_tid <= '0;
        end else begin
          state   <= state_nxt;
          rem     <= rem_nxt;
          cur_tid <= cur_tid_nxt;
        end
      end

      // Tags for the word on in_hs are computed every cycle; state only
      // advances when that word is actually pushed.
      always_comb begin
        state_nxt   = state;
        rem_nxt     = rem;
        cur_tid_nxt = cur_tid;
        in_last     = 1'b1;
        in_tid      = '0;
        case (state)
          S_HEADER: begin
            in_tid = in_hs[23:16];
            if (in_hs[15:0] != 16'd0) begin
              in_last = 1'b0;
              if (push) begin
                rem_nxt     = in_hs[15:0];
                cur_tid_nxt = in_hs[23:16];
                state_nxt   = S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            in_tid  = cur_tid;
            in_last = (rem == 16'd1);
            if (push) begin
              rem_nxt = rem - 16'd1;
              if (rem == 16'd1) state_nxt = S_HEADER;
            end
          end
          default: state_nxt = S_HEADER;
        endcase
      end
    end else begin : g_flat
      assign in_last = 1'b1;
      assign in_tid  = '0;
    end
  endgenerate

  // Side-band fields are cleared on reset so tlast/tid read 0 after reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count       <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      mem_last[0] <= 1'b0;
      mem_last[1] <= 1'b0;
      mem_tid[0]  <= '0;
      mem_tid[1]  <= '0;
    end else begin
      if (push) begin
        mem_last[wr_ptr] <= in_last;
        mem_tid[wr_ptr]  <= in_tid;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // push already implies aresetn high, so data needs no reset.
  always_ff @(posedge aclk) begin
    if (push) mem_data[wr_ptr] <= in_hs;
  end

endmodule
